// File: rtl/coherent_dcache_ctrl.sv
// Direct-mapped, 2-word-block L1 data cache with MSI snooping: fills, writebacks, upgrades, snoop pushes.
// Hits finish combinationally in IDLE; misses, upgrades and snoops stall dhit; bus words advance only on dwait=0.
module coherent_dcache_ctrl #(
  parameter int SETS  = 8,
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 29 - IW;

  typedef enum logic [1:0] {ST_I, ST_S, ST_M} line_t;
  typedef enum logic [3:0] {
    IDLE, UPGRADE, WB1, WB2, RD1, RD2, SNOOP_RESP, PUSH1, PUSH2
  } state_t;

  state_t        state;
  line_t         st_q  [SETS];
  logic [TW-1:0] tag_q [SETS];
  logic [31:0]   w0_q  [SETS];
  logic [31:0]   w1_q  [SETS];
  logic [28:0]   push_blk;
  logic          push_inv;

  logic [IW-1:0] idx, sidx, pidx;
  logic [TW-1:0] tag, stag;
  logic          hit, in_m, s_hit, s_m;
  logic [31:0]   word;
  logic          snoop_busy, inv_keep, inv_ok, upg_lost;
  logic          unused_ok;

  assign idx  = dmemaddr[2+IW:3];
  assign tag  = dmemaddr[31:3+IW];
  assign sidx = ccsnoopaddr[2+IW:3];
  assign stag = ccsnoopaddr[31:3+IW];
  assign pidx = push_blk[IW-1:0];

  assign hit   = (st_q[idx] != ST_I) && (tag_q[idx] == tag);
  assign in_m  = (st_q[idx] == ST_M);
  assign word  = dmemaddr[2] ? w1_q[idx] : w0_q[idx];
  assign s_hit = (st_q[sidx] != ST_I) && (tag_q[sidx] == stag);
  assign s_m   = s_hit && (st_q[sidx] == ST_M);

  // Snoop-time invalidates are owned by SNOOP_RESP; lines mid-fill or mid-push are left alone.
  assign snoop_busy = (state == SNOOP_RESP) || ((state == IDLE) && ccwait);
  assign inv_keep   = (((state == RD1) || (state == RD2)) && (sidx == idx)) ||
                      (((state == PUSH1) || (state == PUSH2)) && (sidx == pidx));
  assign inv_ok     = ccinv && s_hit && !snoop_busy && !inv_keep;
  assign upg_lost   = !hit || (inv_ok && (sidx == idx));

  assign unused_ok = ^{dmemaddr[1:0], ccsnoopaddr[2:0], 1'(CPUID)};

  always_comb begin
    dmemload = '0;
    dhit     = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    cctrans  = 1'b0;
    ccwrite  = 1'b0;
    if (!nRST) begin
      case (state)
        IDLE: begin
          if (!ccwait) begin
            if (dmemREN && hit) begin
              dhit     = 1'b1;
              dmemload = word;
            end else if (dmemWEN && hit && in_m) begin
              dhit = 1'b1;
            end
          end
        end
        UPGRADE: ccwrite = 1'b1;
        WB1, WB2: begin
          dWEN   = 1'b1;
          daddr  = {tag_q[idx], idx, (state == WB2), 2'b00};
          dstore = (state == WB2) ? w1_q[idx] : w0_q[idx];
        end
        RD1, RD2: begin
          dREN    = 1'b1;
          cctrans = 1'b1;
          ccwrite = dmemWEN;
          daddr   = {dmemaddr[31:3], (state == RD2), 2'b00};
        end
        SNOOP_RESP: begin
          cctrans = s_hit;
          ccwrite = s_m;
        end
        PUSH1, PUSH2: begin
          dWEN   = 1'b1;
          daddr  = {push_blk, (state == PUSH2), 2'b00};
          dstore = (state == PUSH2) ? w1_q[pidx] : w0_q[pidx];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state    <= IDLE;
      push_blk <= '0;
      push_inv <= 1'b0;
      for (int i = 0; i < SETS; i++) st_q[i] <= ST_I;
    end else begin
      if (inv_ok) st_q[sidx] <= ST_I;
      case (state)
        IDLE: begin
          if (ccwait) begin
            state <= SNOOP_RESP;
          end else if (dmemWEN && hit && in_m) begin
            if (dmemaddr[2]) w1_q[idx] <= dmemstore;
            else             w0_q[idx] <= dmemstore;
          end else if (dmemWEN && hit) begin
            state <= UPGRADE;
          end else if ((dmemREN || dmemWEN) && !hit) begin
            state <= in_m ? WB1 : RD1;
          end
        end
        UPGRADE: begin
          // Losing the S copy mid-upgrade turns the write into a full BusRdX fill.
          if (upg_lost) begin
            state <= RD1;
          end else begin
            st_q[idx] <= ST_M;
            state     <= IDLE;
          end
        end
        WB1: if (!dwait) state <= WB2;
        WB2: begin
          if (!dwait) begin
            st_q[idx] <= ST_I;
            state     <= RD1;
          end
        end
        RD1: begin
          if (!dwait) begin
            w0_q[idx] <= dload;
            state     <= RD2;
          end
        end
        RD2: begin
          if (!dwait) begin
            w1_q[idx]  <= dload;
            tag_q[idx] <= tag;
            st_q[idx]  <= dmemWEN ? ST_M : ST_S;
            state      <= IDLE;
          end
        end
        SNOOP_RESP: begin
          if (s_m) begin
            push_blk <= ccsnoopaddr[31:3];
            push_inv <= ccinv;
            state    <= PUSH1;
          end else begin
            if (s_hit && ccinv) st_q[sidx] <= ST_I;
            state <= IDLE;
          end
        end
        PUSH1: if (!dwait) state <= PUSH2;
        PUSH2: begin
          if (!dwait) begin
            st_q[pidx] <= push_inv ? ST_I : ST_S;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_coherent_dcache_ctrl.sv
// Scoreboard bench for coherent_dcache_ctrl: queued loads, bus reads and bus writes checked as the DUT produces them.
module tb_coherent_dcache_ctrl;
  logic        CLK;
  logic        nRST;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore, dmemload;
  logic        dhit, dREN, dWEN;
  logic [31:0] daddr, dstore, dload;
  logic        dwait;
  logic        cctrans, ccwrite, ccwait, ccinv;
  logic [31:0] ccsnoopaddr;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } bus_wr_t;

  int          checks = 0;
  int          failures = 0;
  int          upg_cycles = 0;
  logic [31:0] load_q [$];
  logic [31:0] rd_q [$];
  bus_wr_t     wb_q [$];

  coherent_dcache_ctrl #(.SETS(8), .CPUID(0)) dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmemload(dmemload), .dhit(dhit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h0000_000A;
      32'h104: return 32'h0000_000B;
      32'h140: return 32'h0000_000C;
      32'h144: return 32'h0000_000D;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Upgrade signature: exclusive intent with no bus transfer and no snoop response.
  always @(negedge CLK) if (ccwrite && !cctrans && !dREN && !dWEN) upg_cycles++;

  // Memory side: each word is held one cycle, then accepted with dwait=0.
  initial begin : bus_model
    int      cnt;
    bus_wr_t e;
    cnt = 0;
    dwait = 1'b1;
    dload = '0;
    forever begin
      @(negedge CLK);
      if (dREN || dWEN) begin
        cnt++;
        if (cnt >= 2) begin
          cnt = 0;
          dwait = 1'b0;
          if (dREN) begin
            dload = mem_word(daddr);
            check_val("fill_cctrans", 32'(cctrans), 32'd1);
            check_val("fill_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) check_val("fill_addr", daddr, rd_q.pop_front());
          end else begin
            check_val("bus_wr_expected", 32'(wb_q.size() != 0), 32'd1);
            if (wb_q.size() != 0) begin
              e = wb_q.pop_front();
              check_val("bus_wr_addr", daddr, e.a);
              check_val("bus_wr_data", dstore, e.d);
            end
          end
        end
      end else begin
        cnt = 0;
      end
      @(posedge CLK);
      #1 dwait = 1'b1;
    end
  end

  task automatic chk_quiet(input string pfx);
    check_val({pfx, "_dhit"}, 32'(dhit), 32'd0);
    check_val({pfx, "_dREN"}, 32'(dREN), 32'd0);
    check_val({pfx, "_dWEN"}, 32'(dWEN), 32'd0);
    check_val({pfx, "_cctrans"}, 32'(cctrans), 32'd0);
    check_val({pfx, "_ccwrite"}, 32'(ccwrite), 32'd0);
    check_val({pfx, "_daddr"}, daddr, 32'd0);
    check_val({pfx, "_dstore"}, dstore, 32'd0);
    check_val({pfx, "_dmemload"}, dmemload, 32'd0);
  endtask

  task automatic dp_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_load, input int exp_lat);
    int lat;
    bit done;
    if (!wr) load_q.push_back(exp_load);
    @(posedge CLK);
    #1;
    dmemREN = !wr;
    dmemWEN = wr;
    dmemaddr = a;
    dmemstore = wd;
    lat = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (dhit) begin
        done = 1'b1;
        if (!wr && load_q.size() != 0) check_val("load_data", dmemload, load_q.pop_front());
        check_val("hit_latency", 32'(lat), 32'(exp_lat));
      end else begin
        lat++;
      end
    end
    check_val("dhit_seen", 32'(done), 32'd1);
    if (!done && !wr && load_q.size() != 0) void'(load_q.pop_front());
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  task automatic snoop(input logic [31:0] a, input bit inv, input bit exp_tr, input bit exp_wr);
    @(posedge CLK);
    #1;
    ccwait = 1'b1;
    ccsnoopaddr = a;
    ccinv = inv;
    @(negedge CLK);
    check_val("snoop_c1_cctrans", 32'(cctrans), 32'd0);
    @(negedge CLK);
    check_val("snoop_cctrans", 32'(cctrans), 32'(exp_tr));
    check_val("snoop_ccwrite", 32'(ccwrite), 32'(exp_wr));
    @(posedge CLK);
    #1;
    ccwait = 1'b0;
    ccinv = 1'b0;
    for (int i = 0; i < 20 && (wb_q.size() != 0 || dWEN); i++) @(negedge CLK);
    check_val("snoop_push_drained", 32'(wb_q.size()), 32'd0);
  endtask

  initial begin : main
    int u0;
    bit found;
    nRST = 1'b1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    dmemaddr = '0;
    dmemstore = '0;
    ccwait = 1'b0;
    ccinv = 1'b0;
    ccsnoopaddr = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_quiet("rst_hold");
    @(posedge CLK);
    #1 nRST = 1'b0;
    @(negedge CLK);
    chk_quiet("post_rst");

    // Cold read, then sibling word hits immediately.
    rd_q.push_back(32'h100); rd_q.push_back(32'h104);
    dp_req(1'b0, 32'h100, '0, 32'h0000_000A, 5);
    dp_req(1'b0, 32'h104, '0, 32'h0000_000B, 0);

    // Write to an S line: one upgrade cycle, then the write hits.
    u0 = upg_cycles;
    dp_req(1'b1, 32'h100, 32'h1111_1111, '0, 2);
    check_val("upgrade_cycles_1", 32'(upg_cycles - u0), 32'd1);
    dp_req(1'b0, 32'h100, '0, 32'h1111_1111, 0);

    // Snoop on M without invalidate: push both words, keep S.
    wb_q.push_back('{a: 32'h100, d: 32'h1111_1111});
    wb_q.push_back('{a: 32'h104, d: 32'h0000_000B});
    snoop(32'h100, 1'b0, 1'b1, 1'b1);
    dp_req(1'b0, 32'h104, '0, 32'h0000_000B, 0);
    u0 = upg_cycles;
    dp_req(1'b1, 32'h104, 32'h2222_2222, '0, 2);
    check_val("upgrade_cycles_2", 32'(upg_cycles - u0), 32'd1);

    // Conflict miss with dirty victim: writeback then fill.
    wb_q.push_back('{a: 32'h100, d: 32'h1111_1111});
    wb_q.push_back('{a: 32'h104, d: 32'h2222_2222});
    rd_q.push_back(32'h140); rd_q.push_back(32'h144);
    dp_req(1'b0, 32'h140, '0, 32'h0000_000C, 9);
    check_val("wb_drained", 32'(wb_q.size()), 32'd0);

    // S hit with invalidate, then a snoop miss; the invalidated line must refill.
    snoop(32'h140, 1'b1, 1'b1, 1'b0);
    snoop(32'h300, 1'b0, 1'b0, 1'b0);
    rd_q.push_back(32'h140); rd_q.push_back(32'h144);
    dp_req(1'b0, 32'h144, '0, 32'h0000_000D, 5);

    // Fill set 1, then reset in the middle of a conflicting fill.
    rd_q.push_back(32'h108); rd_q.push_back(32'h10C);
    dp_req(1'b0, 32'h10C, '0, mem_word(32'h10C), 5);
    rd_q.push_back(32'h188);
    @(posedge CLK);
    #1;
    dmemREN = 1'b1;
    dmemaddr = 32'h188;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (dREN && daddr == 32'h18C) found = 1'b1;
    end
    check_val("reach_rd2", 32'(found), 32'd1);
    @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    dmemREN = 1'b0;
    @(negedge CLK);
    chk_quiet("mid_rst");
    rd_q.push_back(32'h108); rd_q.push_back(32'h10C);
    dp_req(1'b0, 32'h108, '0, mem_word(32'h108), 5);

    check_val("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check_val("wb_q_final", 32'(wb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
